// File: rtl/morse_pkg.sv
// Shared constants for the Morse letter transmitter: state codes, unit counts and letter table.
// The LGAP state is only reachable when MORSE_LETTER_GAP_EN is defined.
package morse_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MARK  = 3'd2;
  localparam logic [2:0] ST_SPACE = 3'd3;
  localparam logic [2:0] ST_LGAP  = 3'd4;

  localparam logic [1:0] DOT_UNITS   = 2'd1;
  localparam logic [1:0] DASH_UNITS  = 2'd3;
  localparam logic [1:0] SPACE_UNITS = 2'd1;
  localparam logic [1:0] LGAP_UNITS  = 2'd3;

  typedef struct packed {
    logic [2:0] size;
    logic [3:0] pattern;
  } letter_t;

  // Element 0 (rightmost) is letter A; pattern bit3 is the first symbol, 1 = dash.
  localparam logic [7:0][2:0] LETTER_SIZE = {
    3'd4, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd4, 3'd2
  };
  localparam logic [7:0][3:0] LETTER_PATTERN = {
    4'b0000, 4'b1100, 4'b0010, 4'b0000, 4'b1000, 4'b1010, 4'b1000, 4'b0100
  };

  function automatic letter_t letter_lookup(input logic [2:0] code);
    letter_t e;
    e.size    = LETTER_SIZE[code];
    e.pattern = LETTER_PATTERN[code];
    return e;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: after a restart, pulses expire for one cycle once units*TICK_DIV clocks have elapsed.
// Divider and unit counter are down-counters; idle (disarmed) after the expire pulse.
module morse_unit_timer #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [1:0] units,
  output logic       expire
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       unit_cnt;
  logic             armed;

  assign expire = armed && (div_cnt == '0) && (unit_cnt == 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      unit_cnt <= 2'd0;
      armed    <= 1'b0;
    end else if (restart) begin
      div_cnt  <= DIV_LAST;
      unit_cnt <= units - 2'd1;
      armed    <= 1'b1;
    end else if (armed) begin
      if (div_cnt == '0) begin
        if (unit_cnt == 2'd0) begin
          armed <= 1'b0;
        end else begin
          unit_cnt <= unit_cnt - 2'd1;
          div_cnt  <= DIV_LAST;
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse letter sequencer: captures a letter on start and plays its dots/dashes on led.
// Define MORSE_LETTER_GAP_EN to append a 3-unit inter-letter gap before done.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | letter captured, one-cycle setup
// MARK     | led on for a dot or dash
// SPACE    | led off between symbols
// LGAP     | led off inter-letter gap (MORSE_LETTER_GAP_EN only)
module morse_tx_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] letter,
  output logic       led,
  output logic       busy,
  output logic       done
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] size;
  logic [2:0] size_dec;
  logic [3:0] pattern;
  logic [1:0] units;
  logic       restart;
  logic       expire;
  letter_t    entry;

  assign entry    = letter_lookup(letter);
  assign size_dec = size - 3'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_MARK;
      ST_MARK: begin
        if (expire) begin
          if (size_dec != 3'd0) begin
            state_nxt = ST_SPACE;
          end else begin
`ifdef MORSE_LETTER_GAP_EN
            state_nxt = ST_LGAP;
`else
            state_nxt = ST_IDLE;
`endif
          end
        end
      end
      ST_SPACE: if (expire) state_nxt = ST_MARK;
      ST_LGAP:  if (expire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Timer reloads on the edge that enters a timed state, so every interval is whole units.
  always_comb begin
    units   = DOT_UNITS;
    restart = (state_nxt != state);
    case (state_nxt)
      ST_MARK:  units = pattern[3] ? DASH_UNITS : DOT_UNITS;
      ST_SPACE: units = SPACE_UNITS;
      ST_LGAP:  units = LGAP_UNITS;
      default:  restart = 1'b0;
    endcase
  end

  morse_unit_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .units   (units),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      size    <= 3'd0;
      pattern <= 4'd0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      led   <= (state_nxt == ST_MARK);
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      if ((state == ST_IDLE) && start) begin
        size    <= entry.size;
        pattern <= entry.pattern;
      end else if ((state == ST_MARK) && expire) begin
        size    <= size_dec;
        pattern <= {pattern[2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Self-checking bench for morse_tx_ctrl: directed letters, reset abort, then randomized letters
// with spurious start pulses, compared cycle-by-cycle against a dot/dash reference model.
module tb_morse_tx_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       led, busy, done;

  int checks = 0;
  int failures = 0;

  string code [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  logic [2:0] exp_q [$];

  morse_tx_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .letter  (letter),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: {led,busy,done} got %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected {led,busy,done} for each cycle after the start-accept edge, through the done cycle.
  function automatic void build_expected(input int l);
    string s;
    byte   c;
    int    n;
    s = code[l];
    exp_q.delete();
    exp_q.push_back(3'b010);
    for (int j = 0; j < s.len(); j++) begin
      c = s[j];
      n = (c == "-") ? 3 * TD : TD;
      repeat (n) exp_q.push_back(3'b110);
      if (j < s.len() - 1) repeat (TD) exp_q.push_back(3'b010);
    end
`ifdef MORSE_LETTER_GAP_EN
    repeat (3 * TD) exp_q.push_back(3'b010);
`endif
    exp_q.push_back(3'b001);
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic send(input int l, input bit noise);
    int len;
    build_expected(l);
    len = exp_q.size();
    start  = 1'b1;
    letter = 3'(l);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("ltr%0d_cyc%0d", l, i), {led, busy, done}, exp_q[i]);
      start  = noise && (i < len - 1) && ($urandom_range(0, 2) == 0);
      letter = 3'($urandom);
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", {led, busy, done}, 3'b000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset", {led, busy, done}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    send(4, 1'b0);
    idle(1);
    send(0, 1'b0);
    idle(1);
    send(7, 1'b0);
    idle(1);
    send(2, 1'b1);
    idle(1);

    // B aborted by reset two cycles into its second mark.
    build_expected(1);
    start  = 1'b1;
    letter = 3'd1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check($sformatf("b_abort_cyc%0d", i), {led, busy, done}, exp_q[i]);
      start = 1'b0;
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst_async", {led, busy, done}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    send(6, 1'b0);
    idle(1);

    // Back-to-back: start raised in the done cycle.
    send(4, 1'b0);
    send(0, 1'b1);
    idle(1);

    repeat (30) begin
      send($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
